// File: rtl/addr_mem_slave.sv
// Single-port synchronous memory slave: writes store, reads return data one cycle later,
// out-of-range addresses are rejected with an error strobe; saturating activity counters.
module addr_mem_slave #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 48,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              clr_cnt,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              err,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              legal;
    logic              do_wr;
    logic              do_rd;
    logic              do_err;

    // Full-width unsigned compare: no wrap or modulo mapping of high addresses.
    assign legal  = (32'(addr) < DEPTH);
    assign do_wr  = en && legal && wr;
    assign do_rd  = en && legal && !wr;
    assign do_err = en && !legal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[ADDR_W'(i)] <= '0;
            end
            rdata  <= '0;
            rvalid <= 1'b0;
            err    <= 1'b0;
        end else begin
            rvalid <= do_rd;
            err    <= do_err;
            if (do_wr) begin
                mem[addr] <= wdata;
            end
            if (do_rd) begin
                rdata <= mem[addr];
            end
        end
    end

    // Clear wins over any increment in the same cycle; increments stop at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            err_cnt <= '0;
        end else if (clr_cnt) begin
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            err_cnt <= '0;
        end else begin
            if (do_wr && (wr_cnt != '1)) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
            if (do_rd && (rd_cnt != '1)) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
            if (do_err && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/addr_mem_slave.md
Name: addr_mem_slave

Overview:
Single-port synchronous memory slave that consumes the addr/wr/en command stream produced by the stimulus stage. Commands are sampled on the rising edge of clk.
- Writes store wdata.
- Reads return data one cycle later with a valid strobe.
- Addresses at or above DEPTH are rejected with an error pulse.
- Saturating write, read and error counters are kept for bench scoreboarding.

Parameters:
ADDR_W, 6, address width in bits
DATA_W, 8, data word width in bits
DEPTH, 48, number of implemented words; legal addresses are 0..DEPTH-1; DEPTH <= 2**ADDR_W
CNT_W, 8, width of each transaction counter

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  command enable; command is valid when high at a rising edge
wr  input  1  1 = write, 0 = read; ignored when en=0
addr  input  ADDR_W  word address of command
wdata  input  DATA_W  write data, sampled with en=1, wr=1
clr_cnt  input  1  synchronous clear of all three counters
rdata  output  DATA_W  read data, registered
rvalid  output  1  one-cycle strobe: rdata holds a legal read result
err  output  1  one-cycle strobe: previous cycle's command had addr >= DEPTH
wr_cnt  output  CNT_W  count of accepted writes
rd_cnt  output  CNT_W  count of accepted reads
err_cnt  output  CNT_W  count of rejected commands

Behaviour:
- Reset (rst=1, asynchronous): all memory words, rdata, wr_cnt, rd_cnt and err_cnt go to 0; rvalid and err go to 0.
  - State stays reset while rst is high.
  - Release takes effect at the first rising edge with rst=0.
  - Reset asserted mid-sequence aborts any pending read strobe: rvalid=0 immediately.
- Command decode at each rising edge (rst=0); exactly one case applies:
  - en=0: no memory access. Next cycle rvalid=0, err=0; rdata holds its last value.
  - en=1, wr=1, addr<DEPTH: mem[addr] <= wdata; wr_cnt increments. Next cycle rvalid=0, err=0; rdata holds.
  - en=1, wr=0, addr<DEPTH: rdata <= mem[addr] (value before this edge); rd_cnt increments. Next cycle rvalid=1, err=0. Read latency = 1 cycle.
  - en=1, addr>=DEPTH (read or write): no memory access; memory unchanged; err_cnt increments. Next cycle err=1, rvalid=0; rdata holds.
- Back-to-back commands are accepted every cycle with no stall.
  - A read one cycle after a write to the same address returns the new data.
  - rvalid/err may be high on consecutive cycles.
- Counters saturate at 2**CNT_W-1; further increments are dropped.
- clr_cnt=1 at a rising edge sets all counters to 0 and takes priority over any increment in the same cycle. The command itself still executes (memory write, rdata, rvalid, err).
- Addresses are compared as unsigned values on the full ADDR_W bits; there is no wrap-around or modulo mapping.
- err and rvalid are never high in the same cycle.

Test Plan:
1. Reset then idle (en=0) for 5 cycles -> rdata=0, rvalid=0, err=0, all counters 0. Assert rst mid-read -> rvalid drops to 0 immediately.
2. Write addr=12 wdata=0xA5 and addr=14 wdata=0x3C, then read addr=12 and addr=14 -> rvalid=1 with rdata=0xA5 on the cycle after the first read and 0x3C on the next; wr_cnt=2, rd_cnt=2.
3. Read never-written addr=23 -> rdata=0x00, rvalid=1. Write addr=47 wdata=0x7E, then read addr=47 on the next cycle -> rdata=0x7E.
4. Write addr=48 and read addr=56 (DEPTH=48) -> err=1 on each following cycle, rvalid=0, rdata unchanged, err_cnt=2. A subsequent read of addr=47 still returns 0x7E.
5. 260 consecutive legal writes with CNT_W=8 -> wr_cnt stays at 255. Pulse clr_cnt together with a write -> all counters read 0 next cycle and the write is stored.
6. en=0 with wr=1, addr=12, wdata=0xFF -> mem[12] is unchanged (a later read returns 0xA5) and no counter moves.
